mood_update_scheduler: RTL and testbench

Time-multiplexes one shared saturating add/subtract unit across the three mood registers: energy (ch0), stress (ch1) and pleasure (ch2). It replaces the three per-mood saturating counters. On each model tick it captures the inc/dec requests from the regulators. It then serves the pending channels round-robin, one per cycle, and presents the mood values to the range classifiers.

---
 rtl/mood_update_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_mood_update_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mood_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mood_update_scheduler
// Desc     : One shared saturating add/sub unit serving the energy, stress and
//            pleasure mood registers round-robin, one channel per cycle.
//            Optional idle decay toward defaults: define MOOD_DECAY_EN.
// Revision : 1.0  initial release
// ============================================================================
module mood_update_scheduler #(
    parameter int N                = 7,
    parameter int STEP             = 1,
    parameter int SET_VAL          = 64,
    parameter int ENERGY_DEFAULT   = 96,
    parameter int STRESS_DEFAULT   = 0,
    parameter int PLEASURE_DEFAULT = 64,
    parameter int DECAY_TICKS      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [2:0]   inc,
    input  logic [2:0]   dec,
    input  logic         setval,
    output logic [N-1:0] energy,
    output logic [N-1:0] stress,
    output logic [N-1:0] pleasure,
    output logic         busy,
    output logic         upd_valid,
    output logic [1:0]   upd_ch,
    output logic         overrun
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SERVE = 1'b1} state_t;

    localparam logic [N:0]   c_max  = {1'b0, {N{1'b1}}};
    localparam logic [N:0]   c_step = (N+1)'(STEP);
    localparam logic [N-1:0] c_set  = N'(SET_VAL);
    localparam logic [N-1:0] c_def0 = N'(ENERGY_DEFAULT);
    localparam logic [N-1:0] c_def1 = N'(STRESS_DEFAULT);
    localparam logic [N-1:0] c_def2 = N'(PLEASURE_DEFAULT);

    function automatic logic [1:0] f_next(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    state_t       r_state;
    logic [N-1:0] r_val [0:2];
    logic [2:0]   r_pend;
    logic [2:0]   r_op_add;
    logic [1:0]   r_start;
    logic [1:0]   r_rr;
    logic         r_busy;
    logic         r_upd_valid;
    logic [1:0]   r_upd_ch;
    logic         r_overrun;
    logic         r_cap;
    logic [2:0]   r_cap_inc;
    logic [2:0]   r_cap_dec;

    logic [2:0]   w_req_add;
    logic [2:0]   w_req_sub;
    logic [2:0]   w_dk_add;
    logic [2:0]   w_dk_sub;
    logic [2:0]   w_add;
    logic [2:0]   w_sub;
    logic         w_any;
    logic         w_accept;
    logic [1:0]   w_rr_next;
    logic [1:0]   w_c1;
    logic [1:0]   w_c2;
    logic         w_found;
    logic [1:0]   w_sel;
    logic [2:0]   w_sel_mask;
    logic [2:0]   w_pend_left;
    logic [N-1:0] w_cur;
    logic [N:0]   w_sum;
    logic [N:0]   w_dif;
    logic [N-1:0] w_new;

    // Requests are sampled into a capture stage; the scheduler acts on them one edge later.
    assign w_req_add = r_cap_inc & ~r_cap_dec;
    assign w_req_sub = r_cap_dec & ~r_cap_inc;
    assign w_add     = w_req_add | w_dk_add;
    assign w_sub     = w_req_sub | w_dk_sub;
    assign w_any     = |(w_add | w_sub);
    assign w_accept  = tick && !r_busy && !r_cap;
    assign w_rr_next = f_next(r_rr);

`ifdef MOOD_DECAY_EN
    localparam int c_cw = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DECAY_TICKS - 1);

    for (genvar g = 0; g < 3; g++) begin : g_decay
        logic [c_cw-1:0] r_idle;
        logic [N-1:0]    w_def;
        logic            w_nop;
        logic            w_hit;

        assign w_def = (g == 0) ? c_def0 : (g == 1) ? c_def1 : c_def2;
        assign w_nop = !(w_req_add[g] || w_req_sub[g]);
        assign w_hit = w_nop && (r_idle == c_last);
        assign w_dk_add[g] = w_hit && (r_val[g] < w_def);
        assign w_dk_sub[g] = w_hit && (r_val[g] > w_def);

        always_ff @(posedge clk) begin
            if (rst || setval) begin
                r_idle <= '0;
            end else if (r_cap && r_state == S_IDLE) begin
                r_idle <= (w_hit || !w_nop) ? '0 : r_idle + 1'b1;
            end
        end
    end
`else
    logic w_unused_decay;
    assign w_dk_add       = '0;
    assign w_dk_sub       = '0;
    assign w_unused_decay = (DECAY_TICKS > 0);
`endif

    assign w_c1 = f_next(r_start);
    assign w_c2 = f_next(w_c1);

    always_comb begin
        w_found = 1'b1;
        w_sel   = 2'd0;
        if (r_pend[r_start])   w_sel = r_start;
        else if (r_pend[w_c1]) w_sel = w_c1;
        else if (r_pend[w_c2]) w_sel = w_c2;
        else                   w_found = 1'b0;
        w_sel_mask  = 3'b001 << w_sel;
        w_pend_left = r_pend & ~w_sel_mask;
        case (w_sel)
            2'd0:    w_cur = r_val[0];
            2'd1:    w_cur = r_val[1];
            default: w_cur = r_val[2];
        endcase
        // Widened by one bit so overflow and underflow are visible before clamping.
        w_sum = {1'b0, w_cur} + c_step;
        w_dif = {1'b0, w_cur} - c_step;
        if (r_op_add[w_sel]) w_new = (w_sum > c_max) ? c_max[N-1:0] : w_sum[N-1:0];
        else                 w_new = w_dif[N] ? '0 : w_dif[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val[0]    <= c_def0;
            r_val[1]    <= c_def1;
            r_val[2]    <= c_def2;
            r_pend      <= '0;
            r_op_add    <= '0;
            r_start     <= 2'd0;
            r_rr        <= 2'd0;
            r_busy      <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_ch    <= 2'd0;
            r_overrun   <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_inc   <= '0;
            r_cap_dec   <= '0;
            r_state     <= S_IDLE;
        end else if (setval) begin
            r_val[0]    <= c_set;
            r_val[1]    <= c_set;
            r_val[2]    <= c_set;
            r_pend      <= '0;
            r_busy      <= 1'b0;
            r_upd_valid <= 1'b0;
            r_upd_ch    <= 2'd0;
            r_cap       <= 1'b0;
            r_state     <= S_IDLE;
        end else begin
            r_upd_valid <= 1'b0;
            r_upd_ch    <= 2'd0;
            r_cap       <= w_accept;
            if (w_accept) begin
                r_cap_inc <= inc;
                r_cap_dec <= dec;
            end
            if (tick && !w_accept) r_overrun <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_cap) begin
                        r_rr <= w_rr_next;
                        if (w_any) begin
                            r_pend   <= w_add | w_sub;
                            r_op_add <= w_add;
                            r_start  <= r_rr;
                            r_busy   <= 1'b1;
                            r_state  <= S_SERVE;
                        end
                    end
                end
                S_SERVE: begin
                    if (w_found) begin
                        for (int c = 0; c < 3; c++) begin
                            if (w_sel == 2'(c)) r_val[c] <= w_new;
                        end
                        r_pend      <= w_pend_left;
                        r_upd_valid <= 1'b1;
                        r_upd_ch    <= w_sel;
                        if (w_pend_left == 3'b000) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign energy    = r_val[0];
    assign stress    = r_val[1];
    assign pleasure  = r_val[2];
    assign busy      = r_busy;
    assign upd_valid = r_upd_valid;
    assign upd_ch    = r_upd_ch;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_mood_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mood_update_scheduler
// Desc     : Directed plus random stimulus against a transaction-level model
//            of the mood scheduler; follows MOOD_DECAY_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_mood_update_scheduler;
    localparam int N           = 7;
    localparam int STEP        = 1;
    localparam int SET_VAL     = 64;
    localparam int DECAY_TICKS = 8;
    localparam int VMAX        = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic [2:0]   inc = '0;
    logic [2:0]   dec = '0;
    logic         setval = 1'b0;
    logic [N-1:0] energy;
    logic [N-1:0] stress;
    logic [N-1:0] pleasure;
    logic         busy;
    logic         upd_valid;
    logic [1:0]   upd_ch;
    logic         overrun;

    mood_update_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .inc(inc), .dec(dec), .setval(setval),
        .energy(energy), .stress(stress), .pleasure(pleasure), .busy(busy),
        .upd_valid(upd_valid), .upd_ch(upd_ch), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // Reference model: values, round-robin pointer and a queue of scheduled writes.
    int m_val [3];
    int m_idle [3];
    int m_rr;
    bit m_ovr;
    int m_blocked;
    int q_first;
    int q_ch [$];
    bit q_add [$];
    bit exp_uv;
    int exp_uc;
    bit exp_busy;

    function automatic int dflt(input int ch);
        return (ch == 0) ? 96 : (ch == 1) ? 0 : 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_no);
        end
    endtask

    task automatic model_edge();
        int ops [3];
        exp_uv = 1'b0;
        exp_uc = 0;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin m_val[c] = dflt(c); m_idle[c] = 0; end
            m_rr = 0; m_ovr = 1'b0; m_blocked = -1;
            q_ch.delete(); q_add.delete();
        end else if (setval) begin
            for (int c = 0; c < 3; c++) begin m_val[c] = SET_VAL; m_idle[c] = 0; end
            q_ch.delete(); q_add.delete();
            m_blocked = edge_no;
        end else begin
            if (q_ch.size() > 0 && edge_no >= q_first) begin
                int ch;
                bit a;
                ch = q_ch.pop_front();
                a  = q_add.pop_front();
                if (a) m_val[ch] = (m_val[ch] + STEP > VMAX) ? VMAX : m_val[ch] + STEP;
                else   m_val[ch] = (m_val[ch] - STEP < 0) ? 0 : m_val[ch] - STEP;
                exp_uv  = 1'b1;
                exp_uc  = ch;
                q_first = edge_no + 1;
            end
            if (tick) begin
                if (edge_no <= m_blocked) begin
                    m_ovr = 1'b1;
                end else begin
                    int n;
                    for (int c = 0; c < 3; c++)
                        ops[c] = (inc[c] && !dec[c]) ? 1 : (dec[c] && !inc[c]) ? 2 : 0;
`ifdef MOOD_DECAY_EN
                    for (int c = 0; c < 3; c++) begin
                        if (ops[c] != 0) m_idle[c] = 0;
                        else if (m_idle[c] + 1 == DECAY_TICKS) begin
                            m_idle[c] = 0;
                            if (m_val[c] > dflt(c)) ops[c] = 2;
                            else if (m_val[c] < dflt(c)) ops[c] = 1;
                        end else m_idle[c]++;
                    end
`endif
                    n = 0;
                    for (int k = 0; k < 3; k++) begin
                        int ch;
                        ch = (m_rr + k) % 3;
                        if (ops[ch] != 0) begin
                            q_ch.push_back(ch);
                            q_add.push_back(ops[ch] == 1);
                            n++;
                        end
                    end
                    m_rr      = (m_rr + 1) % 3;
                    q_first   = edge_no + 2;
                    m_blocked = edge_no + 1 + n;
                end
            end
        end
        exp_busy = (q_ch.size() > 0) && (edge_no >= q_first - 1);
    endtask

    task automatic step(input bit t, input logic [2:0] i, input logic [2:0] d,
                        input bit s, input bit r);
        tick = t; inc = i; dec = d; setval = s; rst = r;
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        chk("energy",    32'(energy),    32'(m_val[0]));
        chk("stress",    32'(stress),    32'(m_val[1]));
        chk("pleasure",  32'(pleasure),  32'(m_val[2]));
        chk("busy",      32'(busy),      32'(exp_busy));
        chk("upd_valid", 32'(upd_valid), 32'(exp_uv));
        chk("upd_ch",    32'(upd_ch),    32'(exp_uc));
        chk("overrun",   32'(overrun),   32'(m_ovr));
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        bit pt;

        // Reset state
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        chk("rst_energy", 32'(energy), 32'd96);
        chk("rst_stress", 32'(stress), 32'd0);
        chk("rst_pleasure", 32'(pleasure), 32'd64);
        chk("rst_busy", 32'(busy), 32'd0);

        // All-increment tick: order 0,1,2, then 1,2,0 on the following tick
        step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        idle(1);
        chk("capture_busy", 32'(busy), 32'd1);
        idle(1);
        chk("order0_a", 32'(upd_ch), 32'd0);
        idle(1);
        chk("order0_b", 32'(upd_ch), 32'd1);
        idle(1);
        chk("order0_c", 32'(upd_ch), 32'd2);
        chk("drain_busy", 32'(busy), 32'd0);
        chk("inc_energy", 32'(energy), 32'd97);
        chk("inc_stress", 32'(stress), 32'd1);
        chk("inc_pleasure", 32'(pleasure), 32'd65);
        step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        idle(2);
        chk("order1_a", 32'(upd_ch), 32'd1);
        idle(1);
        chk("order1_b", 32'(upd_ch), 32'd2);
        idle(1);
        chk("order1_c", 32'(upd_ch), 32'd0);
        idle(2);

        // Saturation at both bounds still consumes a slot
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        step(1'b1, 3'b000, 3'b010, 1'b0, 1'b0);
        idle(2);
        chk("sat_low_pulse", 32'(upd_valid), 32'd1);
        chk("sat_low_ch", 32'(upd_ch), 32'd1);
        chk("sat_low_val", 32'(stress), 32'd0);
        for (int k = 0; k < 35; k++) begin
            step(1'b1, 3'b001, 3'b000, 1'b0, 1'b0);
            idle(2);
        end
        chk("sat_high_val", 32'(energy), 32'd127);

        // Conflicting inc+dec is a NOP
        step(1'b1, 3'b001, 3'b001, 1'b0, 1'b0);
        idle(1);
        chk("nop_busy", 32'(busy), 32'd0);
        idle(1);
        chk("nop_upd", 32'(upd_valid), 32'd0);

        // Overrun, then setval with a simultaneous tick
        step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        step(1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
        chk("overrun_set", 32'(overrun), 32'd1);
        idle(5);
        step(1'b1, 3'b111, 3'b000, 1'b1, 1'b0);
        chk("setval_energy", 32'(energy), 32'd64);
        chk("setval_busy", 32'(busy), 32'd0);
        chk("setval_overrun", 32'(overrun), 32'd1);
        idle(3);

`ifdef MOOD_DECAY_EN
        // Idle decay toward the pleasure default
        step(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'b100, 3'b000, 1'b0, 1'b0);
            idle(3);
        end
        chk("decay_start", 32'(pleasure), 32'd70);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
            idle(3);
        end
        chk("decay_first", 32'(pleasure), 32'd69);
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
            idle(3);
        end
        chk("decay_settle", 32'(pleasure), 32'd64);
`endif

        // Random traffic; setval is never issued the cycle after a tick
        pt = 1'b0;
        for (int k = 0; k < 800; k++) begin
            bit t;
            bit s;
            bit r;
            t = ($urandom_range(0, 2) == 0);
            s = !pt && ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(t, 3'($urandom), 3'($urandom), s, r);
            pt = t;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
